int_add_acc: RTL and testbench

Two-operand signed integer adder/subtractor/accumulator with independent operand widths, a configurable result width, and a valid/ready stream interface on both sides. It is the next-generation integer adder for the datapath. It adds true two's-complement add/subtract and a persistent accumulator. Results are registered through a 2-stage pipeline with backpressure, so the block can sit directly between stream producers and consumers.

---
 rtl/int_add_pkg.sv | 15 +
 rtl/int_add_acc_if.sv | 30 +++
 rtl/int_sat_add.sv | 28 ++
 rtl/int_add_acc.sv | 109 ++++++++++
 tb/tb_int_add_acc.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/int_add_pkg.sv
// Shared types and helpers for the signed integer adder/accumulator.
package int_add_pkg;

  typedef enum logic [1:0] {
    OpAdd  = 2'b00,
    OpSub  = 2'b01,
    OpAcc  = 2'b10,
    OpLoad = 2'b11
  } int_add_op_e;

  function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/int_add_acc_if.sv
// Valid/ready input and output streams of int_add_acc.
interface int_add_acc_if
  import int_add_pkg::*;
#(
  parameter int unsigned W_IN_A = 8,
  parameter int unsigned W_IN_B = 16,
  parameter int unsigned W_ACC  = 32
) ();

  logic              in_valid;
  logic              in_ready;
  logic [W_IN_A-1:0] in_a;
  logic [W_IN_B-1:0] in_b;
  int_add_op_e       in_op;
  logic              out_valid;
  logic              out_ready;
  logic [W_ACC-1:0]  out_x;
  logic              out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_x, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_x, out_ovf
  );

endinterface

// File: rtl/int_sat_add.sv
// Combinational W-bit signed add with overflow flag.
// Saturates on overflow when INT_ADD_ACC_SAT_EN is defined, otherwise wraps.
module int_sat_add #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o
);

  logic [W-1:0] raw;

  always_comb begin
    raw   = a_i + b_i;
    ovf_o = (a_i[W-1] == b_i[W-1]) && (raw[W-1] != a_i[W-1]);
`ifdef INT_ADD_ACC_SAT_EN
    if (ovf_o) begin
      sum_o = a_i[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sum_o = raw;
    end
`else
    sum_o = raw;
`endif
  end

endmodule

// File: rtl/int_add_acc.sv
// Two-stage signed add/sub/accumulate pipeline with valid/ready on both sides.
// Optional saturation of the accumulator add via INT_ADD_ACC_SAT_EN.
module int_add_acc
  import int_add_pkg::*;
#(
  parameter int unsigned W_IN_A = 8,
  parameter int unsigned W_IN_B = 16,
  parameter int unsigned W_ACC  = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  int_add_acc_if.slave bus
);

  if (W_ACC < max_w(W_IN_A, W_IN_B) + 1) begin : g_bad_width
    $error("int_add_acc: W_ACC must be >= max(W_IN_A, W_IN_B) + 1");
  end

  logic             s1_valid_q;
  logic [W_ACC-1:0] s1_val_q;
  int_add_op_e      s1_op_q;
  logic             out_valid_q;
  logic [W_ACC-1:0] out_x_q;
  logic             out_ovf_q;
  logic [W_ACC-1:0] acc_q;

  logic             adv2;
  logic             move;
  logic             in_fire;
  logic [W_ACC-1:0] a_ext;
  logic [W_ACC-1:0] b_ext;
  logic [W_ACC-1:0] s1_val_d;
  logic [W_ACC-1:0] acc_sum;
  logic             acc_ovf;

  assign adv2    = !out_valid_q || bus.out_ready;
  assign move    = s1_valid_q && adv2;
  assign in_fire = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = !s1_valid_q || adv2;
  assign bus.out_valid = out_valid_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_ovf   = out_ovf_q;

  // W_ACC exceeds both operand widths, so the stage-1 sum/difference is exact.
  assign a_ext = {{(W_ACC - W_IN_A){bus.in_a[W_IN_A-1]}}, bus.in_a};
  assign b_ext = {{(W_ACC - W_IN_B){bus.in_b[W_IN_B-1]}}, bus.in_b};

  always_comb begin
    s1_val_d = a_ext + b_ext;
    if (bus.in_op == OpSub) begin
      s1_val_d = a_ext - b_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_val_q   <= '0;
      s1_op_q    <= OpAdd;
    end else if (in_fire) begin
      s1_valid_q <= 1'b1;
      s1_val_q   <= s1_val_d;
      s1_op_q    <= bus.in_op;
    end else if (move) begin
      s1_valid_q <= 1'b0;
    end
  end

  int_sat_add #(
    .W (W_ACC)
  ) u_sat_add (
    .a_i   (acc_q),
    .b_i   (s1_val_q),
    .sum_o (acc_sum),
    .ovf_o (acc_ovf)
  );

  // The accumulator only changes on the s1->s2 move, so a stalled beat never re-applies.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_ovf_q   <= 1'b0;
      acc_q       <= '0;
    end else if (move) begin
      out_valid_q <= 1'b1;
      unique case (s1_op_q)
        OpAdd, OpSub: begin
          out_x_q   <= s1_val_q;
          out_ovf_q <= 1'b0;
        end
        OpLoad: begin
          acc_q     <= s1_val_q;
          out_x_q   <= s1_val_q;
          out_ovf_q <= 1'b0;
        end
        OpAcc: begin
          acc_q     <= acc_sum;
          out_x_q   <= acc_sum;
          out_ovf_q <= acc_ovf;
        end
      endcase
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_int_add_acc.sv
// Directed, table-driven bench for int_add_acc (W_ACC=20 and W_ACC=17 instances).
module tb_int_add_acc;
  import int_add_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  int_add_acc_if #(.W_IN_A(8), .W_IN_B(16), .W_ACC(20)) bus20 ();
  int_add_acc_if #(.W_IN_A(8), .W_IN_B(16), .W_ACC(17)) bus17 ();

  int_add_acc #(.W_IN_A(8), .W_IN_B(16), .W_ACC(20)) u_dut20 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus20)
  );

  int_add_acc #(.W_IN_A(8), .W_IN_B(16), .W_ACC(17)) u_dut17 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus17)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int_add_op_e op;
    logic [7:0]  a;
    logic [15:0] b;
    logic [31:0] exp_x;
    logic        exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit use17, input logic v, input int_add_op_e op,
                       input logic [7:0] a, input logic [15:0] b);
    if (use17) begin
      bus17.in_valid = v; bus17.in_op = op; bus17.in_a = a; bus17.in_b = b;
    end else begin
      bus20.in_valid = v; bus20.in_op = op; bus20.in_a = a; bus20.in_b = b;
    end
  endtask

  task automatic sample(input bit use17, output logic v, output logic [31:0] x,
                        output logic o);
    if (use17) begin
      v = bus17.out_valid; x = 32'(bus17.out_x); o = bus17.out_ovf;
    end else begin
      v = bus20.out_valid; x = 32'(bus20.out_x); o = bus20.out_ovf;
    end
  endtask

  // One beat on an idle pipeline: result must appear at the second negedge after driving.
  task automatic run_beat(input bit use17, input int_add_op_e op, input logic [7:0] a,
                          input logic [15:0] b, input logic [31:0] exp_x,
                          input logic exp_ovf, input string name);
    int          cyc;
    logic        v;
    logic [31:0] x;
    logic        o;
    @(negedge clk);
    drive(use17, 1'b1, op, a, b);
    @(posedge clk);
    @(negedge clk);
    drive(use17, 1'b0, OpAdd, 8'h00, 16'h0000);
    cyc = 1;
    sample(use17, v, x, o);
    while (!v && cyc < 10) begin
      @(negedge clk);
      cyc++;
      sample(use17, v, x, o);
    end
    check({name, "_lat"}, 32'(cyc), 32'd2);
    check({name, "_x"}, x, exp_x);
    check({name, "_ovf"}, {31'd0, o}, {31'd0, exp_ovf});
  endtask

  vec_t        vecs[10];
  logic [7:0]  bp_a[3];
  logic [15:0] bp_b[3];
  logic [31:0] bp_exp[3];
  logic [31:0] got[3];
  logic [31:0] sat_x;
  logic [31:0] acc17;
  int          idx;
  int          n_got;
  int          guard;
  logic        rdy;

  initial begin
    n_tests = 0;
    n_fail  = 0;
`ifdef INT_ADD_ACC_SAT_EN
    sat_x = 32'h0FFFF;
`else
    sat_x = 32'h100FC;
`endif
    acc17 = sat_x;

    vecs[0] = '{OpAdd,  8'h80, 16'h7FFF, 32'h07F7F, 1'b0};  // -128 + 32767
    vecs[1] = '{OpSub,  8'h01, 16'h8000, 32'h08001, 1'b0};  // 1 - (-32768)
    vecs[2] = '{OpLoad, 8'h05, 16'h0000, 32'h00005, 1'b0};
    vecs[3] = '{OpAcc,  8'hFD, 16'h000A, 32'h0000C, 1'b0};  // 5 + (-3 + 10)
    vecs[4] = '{OpAcc,  8'h7F, 16'h7FFF, 32'h0808A, 1'b0};  // 12 + 32894
    vecs[5] = '{OpSub,  8'h80, 16'h7FFF, 32'hF7F81, 1'b0};  // -32895
    vecs[6] = '{OpLoad, 8'h80, 16'h8000, 32'hF7F80, 1'b0};  // acc = -32896
    vecs[7] = '{OpAcc,  8'hFF, 16'hFFFF, 32'hF7F7E, 1'b0};  // -32898
    vecs[8] = '{OpAdd,  8'h00, 16'h0000, 32'h00000, 1'b0};
    vecs[9] = '{OpAcc,  8'h01, 16'h0001, 32'hF7F80, 1'b0};  // ADD left acc alone

    bp_a   = '{8'h01, 8'h0A, 8'hFB};
    bp_b   = '{16'h0002, 16'h0014, 16'h0064};
    bp_exp = '{32'd3, 32'd30, 32'd95};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, OpAdd, 8'h00, 16'h0000);
    drive(1'b1, 1'b0, OpAdd, 8'h00, 16'h0000);
    bus20.out_ready = 1'b1;
    bus17.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid20", {31'd0, bus20.out_valid}, 32'd0);
    check("rst_out_x20", 32'(bus20.out_x), 32'd0);
    check("rst_out_ovf20", {31'd0, bus20.out_ovf}, 32'd0);
    check("rst_in_ready20", {31'd0, bus20.in_ready}, 32'd1);
    check("rst_out_valid17", {31'd0, bus17.out_valid}, 32'd0);
    check("rst_in_ready17", {31'd0, bus17.in_ready}, 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_beat(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_x, vecs[i].exp_ovf,
               $sformatf("vec%0d", i));
    end

    run_beat(1'b1, OpLoad, 8'h7F, 16'h7FFF, 32'h0807E, 1'b0, "w17_load");
    run_beat(1'b1, OpAcc, 8'h7F, 16'h7FFF, sat_x, 1'b1, "w17_acc_ovf");
    run_beat(1'b1, OpAcc, 8'h00, 16'h0000, acc17, 1'b0, "w17_acc_hold");

    // Backpressure: three ADD beats offered while out_ready is low for five cycles.
    @(negedge clk);
    bus20.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      if (c >= 2) begin
        check($sformatf("bp_hold_valid%0d", c), {31'd0, bus20.out_valid}, 32'd1);
        check($sformatf("bp_hold_x%0d", c), 32'(bus20.out_x), bp_exp[0]);
      end
      if (idx < 3) drive(1'b0, 1'b1, OpAdd, bp_a[idx], bp_b[idx]);
      else drive(1'b0, 1'b0, OpAdd, 8'h00, 16'h0000);
      rdy = bus20.in_ready;
      @(posedge clk);
      if (rdy && idx < 3) idx++;
    end
    @(negedge clk);
    check("bp_accepts", 32'(idx), 32'd2);
    check("bp_in_ready_low", {31'd0, bus20.in_ready}, 32'd0);
    bus20.out_ready = 1'b1;
    n_got = 0;
    guard = 0;
    while (n_got < 3 && guard < 20) begin
      if (bus20.out_valid) begin
        got[n_got] = 32'(bus20.out_x);
        n_got++;
      end
      if (idx < 3) drive(1'b0, 1'b1, OpAdd, bp_a[idx], bp_b[idx]);
      else drive(1'b0, 1'b0, OpAdd, 8'h00, 16'h0000);
      rdy = bus20.in_ready;
      @(posedge clk);
      if (rdy && idx < 3) idx++;
      @(negedge clk);
      guard++;
    end
    drive(1'b0, 1'b0, OpAdd, 8'h00, 16'h0000);
    check("bp_count", 32'(n_got), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < n_got) check($sformatf("bp_order%0d", i), got[i], bp_exp[i]);
    end

    // Mid-stream reset with both stages full and acc = 40.
    run_beat(1'b0, OpLoad, 8'd20, 16'd20, 32'd40, 1'b0, "mrst_load");
    @(negedge clk);
    bus20.out_ready = 1'b0;
    drive(1'b0, 1'b1, OpAdd, 8'd1, 16'd1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b1, OpAdd, 8'd2, 16'd2);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, OpAdd, 8'h00, 16'h0000);
    check("mrst_full_valid", {31'd0, bus20.out_valid}, 32'd1);
    check("mrst_full_in_ready", {31'd0, bus20.in_ready}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_out_valid", {31'd0, bus20.out_valid}, 32'd0);
    check("mrst_in_ready", {31'd0, bus20.in_ready}, 32'd1);
    bus20.out_ready = 1'b1;
    run_beat(1'b0, OpAcc, 8'd1, 16'd1, 32'd2, 1'b0, "mrst_acc");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
